// File: rtl/sd_clk_pkg.sv
// Shared types and constants for the SD clock sequencer: controller states,
// power-control codes, CLKCR bit positions and a CLKCR packing helper.
package sd_clk_pkg;

   typedef enum logic [2:0] {
      ST_OFF,
      ST_RAMP,
      ST_INIT,
      ST_RUN,
      ST_STALL,
      ST_SW_WAIT,
      ST_SW_SET,
      ST_GATED
   } sd_clk_state_t;

   localparam logic [1:0] PWR_OFF  = 2'b00;
   localparam logic [1:0] PWR_RAMP = 2'b10;
   localparam logic [1:0] PWR_ON   = 2'b11;

   localparam int CLKEN_BIT  = 8;
   localparam int BYPASS_BIT = 10;

   // Assemble the divider clock-control word; all unlisted bits stay zero.
   function automatic logic [31:0] pack_clkcr(input logic [7:0] div,
                                              input logic       en,
                                              input logic       byp);
      logic [31:0] w;
      w             = '0;
      w[7:0]        = div;
      w[CLKEN_BIT]  = en;
      w[BYPASS_BIT] = byp;
      return w;
   endfunction

endpackage

// File: rtl/sd_clk_tick_mirror.sv
// Mirrors the external divider's toggle timing: while enabled, emits a one-cycle
// strobe every clkdiv_i+1 source cycles, i.e. once per SD clock half-period.
module sd_clk_tick_mirror (
   input  logic       sd_clk_i,
   input  logic       rst,
   input  logic       en_i,
   input  logic [7:0] clkdiv_i,
   output logic       toggle_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // Next count: held at zero while disabled, wraps at the divider terminal count.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (cnt_q == clkdiv_i) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // Half-period counter register.
   always_ff @(posedge sd_clk_i or posedge rst) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign toggle_o = en_i && (cnt_q == clkdiv_i);

endmodule

// File: rtl/sd_clock_ctrl.sv
// SD card clock sequencer: power-up ramp, 74-clock identification burst,
// glitch-free switch to transfer speed, and clock stop on data-path stall.
// Optional feature: define SD_CLK_AUTOGATE_EN to gate the clock after
// IDLE_GATE_CYC idle cycles in RUN.
module sd_clock_ctrl
   import sd_clk_pkg::*;
#(
   parameter int PWR_RAMP_CYC  = 1000,
   parameter int INIT_SD_CLKS  = 74,
   parameter int SETTLE_CYC    = 8,
   parameter int IDLE_GATE_CYC = 64
) (
   input  logic        sd_clk_i,
   input  logic        rst,
   input  logic        pwr_on,
   input  logic [7:0]  div_init,
   input  logic [7:0]  div_xfer,
   input  logic        bypass_xfer,
   input  logic        speed_sw_req,
   input  logic        cmd_busy,
   input  logic        dat_busy,
   input  logic        fifo_stall,
   output logic [31:0] sd_pwr_o,
   output logic [31:0] sd_clkcr_o,
   output logic        init_done,
   output logic        xfer_mode,
   output logic        sw_busy
);

   localparam logic [15:0] RAMP_LAST   = 16'(PWR_RAMP_CYC - 1);
   localparam logic [15:0] TOG_LAST    = 16'(2 * INIT_SD_CLKS - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
`ifdef SD_CLK_AUTOGATE_EN
   localparam logic [15:0] IDLE_LAST   = 16'(IDLE_GATE_CYC - 1);
`endif

   sd_clk_state_t state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;          // ramp / settle / idle cycle counter
   logic [15:0]   tog_cnt_q, tog_cnt_d;  // divider toggles seen during INIT
   logic [1:0]    pwr_q, pwr_d;
   logic [7:0]    clkdiv_q, clkdiv_d;
   logic          clken_q, clken_d;
   logic          bypass_q, bypass_d;
   logic          init_done_q, init_done_d;
   logic          xfer_q, xfer_d;
   logic          sw_pend_q, sw_pend_d;
   logic          toggle;

   sd_clk_tick_mirror u_tick_mirror (
      .sd_clk_i (sd_clk_i),
      .rst      (rst),
      .en_i     (state_q == ST_INIT),
      .clkdiv_i (clkdiv_q),
      .toggle_o (toggle)
   );

   // Next-state and next-output logic; divider fields only move while CLKEN is low.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tog_cnt_d   = tog_cnt_q;
      pwr_d       = pwr_q;
      clkdiv_d    = clkdiv_q;
      clken_d     = clken_q;
      bypass_d    = bypass_q;
      init_done_d = init_done_q;
      xfer_d      = xfer_q;
      sw_pend_d   = sw_pend_q;

      // A switch request is remembered once the clock exists; repeats are absorbed.
      if (speed_sw_req && (state_q != ST_OFF) && (state_q != ST_RAMP)) begin
         sw_pend_d = 1'b1;
      end

      unique case (state_q)
         ST_OFF: begin
            if (pwr_on) begin
               state_d = ST_RAMP;
               pwr_d   = PWR_RAMP;
               cnt_d   = '0;
            end
         end
         ST_RAMP: begin
            if (cnt_q == RAMP_LAST) begin
               state_d   = ST_INIT;
               pwr_d     = PWR_ON;
               clkdiv_d  = div_init;
               bypass_d  = 1'b0;
               clken_d   = 1'b1;
               tog_cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_INIT: begin
            if (toggle) begin
               if (tog_cnt_q == TOG_LAST) begin
                  state_d     = ST_RUN;
                  init_done_d = 1'b1;
                  cnt_d       = '0;
               end else begin
                  tog_cnt_d = tog_cnt_q + 16'd1;
               end
            end
         end
         ST_RUN: begin
            if (fifo_stall && dat_busy) begin
               state_d = ST_STALL;
               clken_d = 1'b0;
            end else if (sw_pend_q && !cmd_busy && !dat_busy) begin
               state_d = ST_SW_WAIT;
               clken_d = 1'b0;
               cnt_d   = '0;
            end
`ifdef SD_CLK_AUTOGATE_EN
            else if (!cmd_busy && !dat_busy) begin
               if (cnt_q == IDLE_LAST) begin
                  state_d = ST_GATED;
                  clken_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end else begin
               cnt_d = '0;
            end
`endif
         end
         ST_STALL: begin
            if (!fifo_stall) begin
               state_d = ST_RUN;
               clken_d = 1'b1;
               cnt_d   = '0;
            end
         end
         ST_SW_WAIT: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d  = ST_SW_SET;
               clkdiv_d = div_xfer;
               bypass_d = bypass_xfer;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_SW_SET: begin
            if (cnt_q == SETTLE_LAST) begin
               state_d   = ST_RUN;
               clken_d   = 1'b1;
               xfer_d    = 1'b1;
               sw_pend_d = 1'b0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
`ifdef SD_CLK_AUTOGATE_EN
         ST_GATED: begin
            if (cmd_busy || dat_busy || speed_sw_req) begin
               state_d = ST_RUN;
               clken_d = 1'b1;
               cnt_d   = '0;
            end
         end
`endif
         default: begin
            state_d = ST_OFF;
         end
      endcase

      // Losing card power overrides everything and returns to a clean OFF.
      if (!pwr_on) begin
         state_d     = ST_OFF;
         cnt_d       = '0;
         tog_cnt_d   = '0;
         pwr_d       = PWR_OFF;
         clkdiv_d    = '0;
         clken_d     = 1'b0;
         bypass_d    = 1'b0;
         init_done_d = 1'b0;
         xfer_d      = 1'b0;
         sw_pend_d   = 1'b0;
      end
   end

   // Controller state and registered outputs.
   always_ff @(posedge sd_clk_i or posedge rst) begin
      if (rst) begin
         state_q     <= ST_OFF;
         cnt_q       <= '0;
         tog_cnt_q   <= '0;
         pwr_q       <= PWR_OFF;
         clkdiv_q    <= '0;
         clken_q     <= 1'b0;
         bypass_q    <= 1'b0;
         init_done_q <= 1'b0;
         xfer_q      <= 1'b0;
         sw_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tog_cnt_q   <= tog_cnt_d;
         pwr_q       <= pwr_d;
         clkdiv_q    <= clkdiv_d;
         clken_q     <= clken_d;
         bypass_q    <= bypass_d;
         init_done_q <= init_done_d;
         xfer_q      <= xfer_d;
         sw_pend_q   <= sw_pend_d;
      end
   end

   assign sd_pwr_o   = {30'd0, pwr_q};
   assign sd_clkcr_o = pack_clkcr(clkdiv_q, clken_q, bypass_q);
   assign init_done  = init_done_q;
   assign xfer_mode  = xfer_q;
   assign sw_busy    = sw_pend_q;

endmodule

// File: tb/tb_sd_clock_ctrl.sv
// Self-checking bench for sd_clock_ctrl: expected output snapshots are queued as
// stimulus is driven and popped when the DUT output is sampled on the falling edge.
module tb_sd_clock_ctrl;

   localparam int RAMP      = 10;
   localparam int INIT_CLKS = 74;
   localparam int SETTLE    = 8;
   localparam int IDLE      = 64;

   localparam logic [1:0] P_OFF  = 2'b00;
   localparam logic [1:0] P_RAMP = 2'b10;
   localparam logic [1:0] P_ON   = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        pwr_on;
   logic [7:0]  div_init;
   logic [7:0]  div_xfer;
   logic        bypass_xfer;
   logic        speed_sw_req;
   logic        cmd_busy;
   logic        dat_busy;
   logic        fifo_stall;
   logic [31:0] sd_pwr_o;
   logic [31:0] sd_clkcr_o;
   logic        init_done;
   logic        xfer_mode;
   logic        sw_busy;

   typedef struct packed {
      logic [31:0] pwr;
      logic [31:0] clkcr;
      logic        init_done;
      logic        xfer;
      logic        sw_busy;
   } snap_t;

   typedef struct {
      string tag;
      snap_t v;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   viol  = 0;

   always #5 clk = ~clk;

   sd_clock_ctrl #(
      .PWR_RAMP_CYC  (RAMP),
      .INIT_SD_CLKS  (INIT_CLKS),
      .SETTLE_CYC    (SETTLE),
      .IDLE_GATE_CYC (IDLE)
   ) dut (
      .sd_clk_i     (clk),
      .rst          (rst),
      .pwr_on       (pwr_on),
      .div_init     (div_init),
      .div_xfer     (div_xfer),
      .bypass_xfer  (bypass_xfer),
      .speed_sw_req (speed_sw_req),
      .cmd_busy     (cmd_busy),
      .dat_busy     (dat_busy),
      .fifo_stall   (fifo_stall),
      .sd_pwr_o     (sd_pwr_o),
      .sd_clkcr_o   (sd_clkcr_o),
      .init_done    (init_done),
      .xfer_mode    (xfer_mode),
      .sw_busy      (sw_busy)
   );

   function automatic snap_t mk(input logic [1:0] p, input logic [7:0] div,
                                input logic en, input logic byp,
                                input logic id, input logic xm, input logic sb);
      snap_t s;
      s.pwr       = {30'd0, p};
      s.clkcr     = '0;
      s.clkcr[7:0] = div;
      s.clkcr[8]  = en;
      s.clkcr[10] = byp;
      s.init_done = id;
      s.xfer      = xm;
      s.sw_busy   = sb;
      return s;
   endfunction

   function automatic snap_t observe();
      snap_t s;
      s.pwr       = sd_pwr_o;
      s.clkcr     = sd_clkcr_o;
      s.init_done = init_done;
      s.xfer      = xfer_mode;
      s.sw_busy   = sw_busy;
      return s;
   endfunction

   // Divider fields may only change while CLKEN is low on both sides of the edge
   // (INIT entry from the ramp and power-off are the sanctioned exceptions).
   logic [31:0] prev_cr  = '0;
   logic [31:0] prev_pwr = '0;
   always @(negedge clk) begin
      if (prev_pwr[1:0] == P_ON && sd_pwr_o[1:0] == P_ON &&
          {prev_cr[10], prev_cr[7:0]} != {sd_clkcr_o[10], sd_clkcr_o[7:0]} &&
          (prev_cr[8] || sd_clkcr_o[8]))
         viol++;
      prev_cr  = sd_clkcr_o;
      prev_pwr = sd_pwr_o;
   end

   task automatic test_reset();
      exp_t  e;
      snap_t o;
      rst = 1'b1; pwr_on = 1'b0; div_init = 8'd4; div_xfer = 8'd1; bypass_xfer = 1'b0;
      speed_sw_req = 1'b0; cmd_busy = 1'b0; dat_busy = 1'b0; fifo_stall = 1'b0;
      repeat (3) @(negedge clk);
      sb_q.push_back('{tag: "reset", v: mk(P_OFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
      rst = 1'b0;
      // A switch request while powered off must not latch.
      for (int i = 0; i < 3; i++) begin
         speed_sw_req = (i == 0);
         sb_q.push_back('{tag: "off_req", v: mk(P_OFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(); total++;
         if (o !== e.v) begin bad++; $display("FAIL %s[%0d]: got %h want %h", e.tag, i, o, e.v); end
      end
      speed_sw_req = 1'b0;
   endtask

   task automatic test_power_up(input logic [7:0] div);
      exp_t  e;
      snap_t o;
      int    cycles;
      bit    en_drop;
      div_init = div;
      pwr_on   = 1'b1;
      for (int i = 0; i < RAMP; i++) begin
         speed_sw_req = (i == 3);
         sb_q.push_back('{tag: "ramp", v: mk(P_RAMP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)});
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(); total++;
         if (o !== e.v) begin bad++; $display("FAIL %s[%0d]: got %h want %h", e.tag, i, o, e.v); end
      end
      speed_sw_req = 1'b0;
      sb_q.push_back('{tag: "init_entry", v: mk(P_ON, div, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)});
      @(negedge clk);
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
      cycles  = 0;
      en_drop = 1'b0;
      while (init_done !== 1'b1 && cycles < 4000) begin
         @(negedge clk);
         cycles++;
         if (sd_clkcr_o[8] !== 1'b1) en_drop = 1'b1;
      end
      total++;
      if (cycles != 2 * INIT_CLKS * (int'(div) + 1)) begin
         bad++;
         $display("FAIL init_len div=%0d: got %0d cycles want %0d", div, cycles,
                  2 * INIT_CLKS * (int'(div) + 1));
      end
      total++;
      if (en_drop) begin bad++; $display("FAIL init_clken: CLKEN dropped during INIT, want held 1"); end
      sb_q.push_back('{tag: "run_after_init", v: mk(P_ON, div, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)});
      @(negedge clk);
      e = sb_q.pop_front(); o = observe(); total++;
      if (o !== e.v) begin bad++; $display("FAIL %s: got %h want %h", e.tag, o, e.v); end
   endtask

   task automatic test_stall();
      exp_t  e;
      snap_t o;
      snap_t run_v, stall_v;
      run_v   = mk(P_ON, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      stall_v = mk(P_ON, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      // 5 cycles of fifo_stall without dat_busy (ignored), 20 real stall cycles, then release.
      for (int i = 0; i < 28; i++) begin
         fifo_stall = (i < 25);
         dat_busy   = (i >= 5 && i < 25);
         sb_q.push_back('{tag: "stall", v: (i >= 5 && i < 25) ? stall_v : run_v});
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(); total++;
         if (o !== e.v) begin bad++; $display("FAIL %s[%0d]: got %h want %h", e.tag, i, o, e.v); end
      end
      fifo_stall = 1'b0;
      dat_busy   = 1'b0;
   endtask

   task automatic test_speed_switch();
      exp_t  e;
      snap_t o;
      snap_t x;
      div_xfer    = 8'd1;
      bypass_xfer = 1'b0;
      for (int i = 0; i < 28; i++) begin
         cmd_busy     = (i < 10);
         speed_sw_req = (i == 0 || i == 5);
         if (i < 10)      x = mk(P_ON, 8'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
         else if (i < 18) x = mk(P_ON, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         else if (i < 26) x = mk(P_ON, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
         else             x = mk(P_ON, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
         sb_q.push_back('{tag: "speed_sw", v: x});
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(); total++;
         if (o !== e.v) begin bad++; $display("FAIL %s[%0d]: got %h want %h", e.tag, i, o, e.v); end
      end
      cmd_busy     = 1'b0;
      speed_sw_req = 1'b0;
   endtask

   task automatic test_back_to_back_bypass();
      exp_t  e;
      snap_t o;
      snap_t x;
      bypass_xfer = 1'b1;
      for (int i = 0; i < 19; i++) begin
         speed_sw_req = (i == 0);
         if (i < 1)       x = mk(P_ON, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
         else if (i < 9)  x = mk(P_ON, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
         else if (i < 17) x = mk(P_ON, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
         else             x = mk(P_ON, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
         sb_q.push_back('{tag: "bypass_sw", v: x});
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(); total++;
         if (o !== e.v) begin bad++; $display("FAIL %s[%0d]: got %h want %h", e.tag, i, o, e.v); end
      end
      speed_sw_req = 1'b0;
   endtask

   task automatic test_idle();
      exp_t  e;
      snap_t o;
      snap_t on_v, off_v;
      on_v  = mk(P_ON, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      off_v = mk(P_ON, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 68; i++) begin
         cmd_busy = (i == 0 || i == 65);
`ifdef SD_CLK_AUTOGATE_EN
         sb_q.push_back('{tag: "autogate", v: (i == IDLE) ? off_v : on_v});
`else
         sb_q.push_back('{tag: "no_gate", v: on_v});
`endif
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(); total++;
         if (o !== e.v) begin bad++; $display("FAIL %s[%0d]: got %h want %h", e.tag, i, o, e.v); end
      end
      cmd_busy = 1'b0;
   endtask

   task automatic test_power_off();
      exp_t  e;
      snap_t o;
      snap_t x;
      for (int i = 0; i < 45; i++) begin
         pwr_on       = !(i < 2 || i >= 42);
         speed_sw_req = (i == 1);
         div_init     = 8'd4;
         if (i < 2 || i >= 42) x = mk(P_OFF, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         else if (i < 12)      x = mk(P_RAMP, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         else                  x = mk(P_ON, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
         sb_q.push_back('{tag: "pwr_off", v: x});
         @(negedge clk);
         e = sb_q.pop_front(); o = observe(); total++;
         if (o !== e.v) begin bad++; $display("FAIL %s[%0d]: got %h want %h", e.tag, i, o, e.v); end
      end
      speed_sw_req = 1'b0;
   endtask

   task automatic test_clkcr_stability();
      total++;
      if (viol != 0) begin
         bad++;
         $display("FAIL clkcr_stable: %0d divider changes with CLKEN high, want 0", viol);
      end
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_power_up(8'd4);
      test_stall();
      test_speed_switch();
      test_back_to_back_bypass();
      test_idle();
      test_power_off();
      test_power_up(8'd0);
      test_clkcr_stability();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
